// File: rtl/taxi_pcie_us_msi_ctrl_pkg.sv
// Shared types and helpers for the UltraScale+ MSI scheduler.
package taxi_pcie_msi_pkg;

  localparam int MSI_VEC_MAX = 32;
  localparam int MSI_VEC_W   = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    BACKOFF = 2'd3
  } msi_state_t;

  // Lanes that exist for a given multi-message-enable encoding (values above 5 clamp to 32).
  function automatic logic [MSI_VEC_MAX-1:0] msi_lane_mask(input logic [2:0] mme);
    logic [MSI_VEC_MAX-1:0] m;
    case (mme)
      3'd0:    m = 32'h0000_0001;
      3'd1:    m = 32'h0000_0003;
      3'd2:    m = 32'h0000_000F;
      3'd3:    m = 32'h0000_00FF;
      3'd4:    m = 32'h0000_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

  // Index mask N-1 used to reduce any vector number modulo the allocated count.
  function automatic logic [MSI_VEC_W-1:0] msi_idx_mask(input logic [2:0] mme);
    logic [MSI_VEC_W-1:0] m;
    case (mme)
      3'd0:    m = 5'd0;
      3'd1:    m = 5'd1;
      3'd2:    m = 5'd3;
      3'd3:    m = 5'd7;
      3'd4:    m = 5'd15;
      default: m = 5'd31;
    endcase
    return m;
  endfunction

  // Fold every pending bit onto (bit & mask) so nothing is lost when the vector count shrinks.
  function automatic logic [MSI_VEC_MAX-1:0] msi_fold(input logic [MSI_VEC_MAX-1:0] p,
                                                      input logic [MSI_VEC_W-1:0]   mask);
    logic [MSI_VEC_MAX-1:0] f;
    f = 32'h0000_0000;
    for (int b = 0; b < MSI_VEC_MAX; b++) begin
      f[MSI_VEC_W'(b) & mask] = f[MSI_VEC_W'(b) & mask] | p[b];
    end
    return f;
  endfunction

endpackage

// File: rtl/taxi_pcie_us_msi_ctrl_if.sv
// Interrupt request handshake between event sources and the MSI scheduler.
interface taxi_pcie_us_msi_ctrl_if #(
  parameter int IRQ_INDEX_W = 11
) ();
  logic                   irq_valid;
  logic [IRQ_INDEX_W-1:0] irq_index;
  logic                   irq_ready;

  modport master (output irq_valid, output irq_index, input irq_ready);
  modport slave  (input irq_valid, input irq_index, output irq_ready);
endinterface

// File: rtl/taxi_pcie_us_msi_ctrl_rr_pick.sv
// Round-robin picker: first set request at or after the pointer, wrapping over 32 lanes.
module taxi_msi_rr_pick
  import taxi_pcie_msi_pkg::*;
(
  input  logic [MSI_VEC_MAX-1:0] req,
  input  logic [MSI_VEC_W-1:0]   ptr,
  output logic                   valid,
  output logic [MSI_VEC_W-1:0]   index
);

  logic [MSI_VEC_W-1:0] idx_s;

  // Scan from the pointer upward; the first hit locks the result.
  always_comb begin
    valid = 1'b0;
    index = 5'd0;
    idx_s = 5'd0;
    for (int i = 0; i < MSI_VEC_MAX; i++) begin
      idx_s = ptr + MSI_VEC_W'(i);
      index = (!valid && req[idx_s]) ? idx_s : index;
      valid = valid | req[idx_s];
    end
  end

endmodule

// File: rtl/taxi_pcie_us_msi_ctrl.sv
// MSI scheduler for the UltraScale+ PCIe cfg_interrupt_msi interface: coalesces
// requests into per-vector pending bits, grants round-robin, one MSI in flight.
module taxi_pcie_us_msi_ctrl
  import taxi_pcie_msi_pkg::*;
#(
  parameter int IRQ_INDEX_W = 11,   // must exceed MSI_VEC_W
  parameter int TIMEOUT     = 1024, // >= 2
  parameter int RETRY_DELAY = 64    // >= 1
) (
  input  logic        clk,
  input  logic        rst_n,
  taxi_pcie_us_msi_ctrl_if.slave irq,
  input  logic [3:0]  cfg_interrupt_msi_enable,
  input  logic [11:0] cfg_interrupt_msi_mmenable,
  output logic [31:0] cfg_interrupt_msi_int,
  input  logic        cfg_interrupt_msi_sent,
  input  logic        cfg_interrupt_msi_fail,
  output logic [1:0]  cfg_interrupt_msi_select,
  output logic [31:0] cfg_interrupt_msi_pending_status,
  output logic        cfg_interrupt_msi_pending_status_data_enable,
  output logic [1:0]  cfg_interrupt_msi_pending_status_function_num,
  output logic [2:0]  cfg_interrupt_msi_attr,
  output logic        cfg_interrupt_msi_tph_present,
  output logic [1:0]  cfg_interrupt_msi_tph_type,
  output logic [7:0]  cfg_interrupt_msi_tph_st_tag,
  output logic [7:0]  cfg_interrupt_msi_function_number,
  output logic        stat_msi_sent,
  output logic        stat_msi_fail
);

  localparam int TO_W = $clog2(TIMEOUT);
  localparam int BO_W = (RETRY_DELAY > 1) ? $clog2(RETRY_DELAY) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [BO_W-1:0] BO_LAST = BO_W'(RETRY_DELAY - 1);

  msi_state_t             state_q, state_d;
  logic [MSI_VEC_MAX-1:0] pending_q, pending_d;
  logic [MSI_VEC_W-1:0]   ptr_q, ptr_d;
  logic [MSI_VEC_W-1:0]   vec_q, vec_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
  logic [BO_W-1:0]        bo_cnt_q, bo_cnt_d;
  logic [MSI_VEC_MAX-1:0] msi_int_q, msi_int_d;
  logic                   stat_sent_q, stat_sent_d;
  logic                   stat_fail_q, stat_fail_d;
  logic                   irq_ready_q, irq_ready_d;

  logic [MSI_VEC_MAX-1:0] lane_mask_s;
  logic [MSI_VEC_W-1:0]   idx_mask_s;
  logic                   irq_fire_s;
  logic [MSI_VEC_W-1:0]   irq_vec_s;
  logic                   pick_valid_s;
  logic [MSI_VEC_W-1:0]   pick_idx_s;
  logic                   clr_s;
  logic [MSI_VEC_MAX-1:0] kept_s;
  logic                   unused_s;

  assign lane_mask_s = msi_lane_mask(cfg_interrupt_msi_mmenable[2:0]);
  assign idx_mask_s  = msi_idx_mask(cfg_interrupt_msi_mmenable[2:0]);
  assign irq_fire_s  = irq.irq_valid & irq_ready_q;
  assign irq_vec_s   = irq.irq_index[MSI_VEC_W-1:0] & idx_mask_s;
  assign unused_s    = ^{cfg_interrupt_msi_enable[3:1], cfg_interrupt_msi_mmenable[11:3],
                         irq.irq_index[IRQ_INDEX_W-1:MSI_VEC_W]};

  // Bits left over from a larger vector count are hidden until folded next cycle.
  taxi_msi_rr_pick u_pick (
    .req   (pending_q & lane_mask_s),
    .ptr   (ptr_q & idx_mask_s),
    .valid (pick_valid_s),
    .index (pick_idx_s)
  );

  // Next-state logic for the issue FSM, counters and registered outputs.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q & idx_mask_s;
    vec_d       = vec_q;
    to_cnt_d    = to_cnt_q;
    bo_cnt_d    = bo_cnt_q;
    msi_int_d   = 32'h0000_0000;
    stat_sent_d = 1'b0;
    stat_fail_d = 1'b0;
    irq_ready_d = 1'b1;
    clr_s       = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_interrupt_msi_enable[0] && pick_valid_s) begin
          vec_d     = pick_idx_s;
          msi_int_d = 32'h0000_0001 << pick_idx_s;
          state_d   = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        to_cnt_d = '0;
        state_d  = WAIT;
      end
      WAIT: begin
        if (cfg_interrupt_msi_sent) begin
          clr_s       = 1'b1;
          stat_sent_d = 1'b1;
          ptr_d       = (vec_q + 5'd1) & idx_mask_s;
          state_d     = IDLE;
        end else if (cfg_interrupt_msi_fail || (to_cnt_q == TO_LAST)) begin
          stat_fail_d = 1'b1;
          ptr_d       = (vec_q + 5'd1) & idx_mask_s;
          bo_cnt_d    = '0;
          state_d     = BACKOFF;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      BACKOFF: begin
        if (bo_cnt_q == BO_LAST) begin
          state_d = IDLE;
        end else begin
          bo_cnt_d = bo_cnt_q + BO_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pending vector update: clear on delivery, fold to current count, new requests win.
  always_comb begin
    kept_s    = pending_q & ~(clr_s ? (32'h0000_0001 << vec_q) : 32'h0000_0000);
    pending_d = msi_fold(kept_s, idx_mask_s) |
                (irq_fire_s ? (32'h0000_0001 << irq_vec_s) : 32'h0000_0000);
  end

  // State and output registers; reset clears everything including any in-flight MSI.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pending_q   <= 32'h0000_0000;
      ptr_q       <= 5'd0;
      vec_q       <= 5'd0;
      to_cnt_q    <= '0;
      bo_cnt_q    <= '0;
      msi_int_q   <= 32'h0000_0000;
      stat_sent_q <= 1'b0;
      stat_fail_q <= 1'b0;
      irq_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      ptr_q       <= ptr_d;
      vec_q       <= vec_d;
      to_cnt_q    <= to_cnt_d;
      bo_cnt_q    <= bo_cnt_d;
      msi_int_q   <= msi_int_d;
      stat_sent_q <= stat_sent_d;
      stat_fail_q <= stat_fail_d;
      irq_ready_q <= irq_ready_d;
    end
  end

  assign irq.irq_ready                                 = irq_ready_q;
  assign cfg_interrupt_msi_int                         = msi_int_q;
  assign stat_msi_sent                                 = stat_sent_q;
  assign stat_msi_fail                                 = stat_fail_q;
  assign cfg_interrupt_msi_select                      = 2'd0;
  assign cfg_interrupt_msi_pending_status              = 32'h0000_0000;
  assign cfg_interrupt_msi_pending_status_data_enable  = 1'b0;
  assign cfg_interrupt_msi_pending_status_function_num = 2'd0;
  assign cfg_interrupt_msi_attr                        = 3'd0;
  assign cfg_interrupt_msi_tph_present                 = 1'b0;
  assign cfg_interrupt_msi_tph_type                    = 2'd0;
  assign cfg_interrupt_msi_tph_st_tag                  = 8'd0;
  assign cfg_interrupt_msi_function_number             = 8'd0;

endmodule

// File: tb/tb_taxi_pcie_us_msi_ctrl.sv
// Scoreboard bench for the MSI scheduler: expected vectors are queued when
// requests are driven and popped when an MSI pulse appears.
module tb_taxi_pcie_us_msi_ctrl;

  localparam int TO = 32;
  localparam int RD = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  msi_enable;
  logic [11:0] mmenable;
  logic        sent, fail;
  logic [31:0] msi_int, pend_status;
  logic [1:0]  sel, pend_fn, tph_type;
  logic        pend_de, tph_present, stat_sent, stat_fail;
  logic [2:0]  attr;
  logic [7:0]  st_tag, fn_num;

  int checks = 0;
  int passed = 0;
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  taxi_pcie_us_msi_ctrl_if #(.IRQ_INDEX_W(11)) irq_if ();

  taxi_pcie_us_msi_ctrl #(.IRQ_INDEX_W(11), .TIMEOUT(TO), .RETRY_DELAY(RD)) dut (
    .clk(clk), .rst_n(rst_n), .irq(irq_if),
    .cfg_interrupt_msi_enable(msi_enable), .cfg_interrupt_msi_mmenable(mmenable),
    .cfg_interrupt_msi_int(msi_int), .cfg_interrupt_msi_sent(sent), .cfg_interrupt_msi_fail(fail),
    .cfg_interrupt_msi_select(sel), .cfg_interrupt_msi_pending_status(pend_status),
    .cfg_interrupt_msi_pending_status_data_enable(pend_de),
    .cfg_interrupt_msi_pending_status_function_num(pend_fn),
    .cfg_interrupt_msi_attr(attr), .cfg_interrupt_msi_tph_present(tph_present),
    .cfg_interrupt_msi_tph_type(tph_type), .cfg_interrupt_msi_tph_st_tag(st_tag),
    .cfg_interrupt_msi_function_number(fn_num),
    .stat_msi_sent(stat_sent), .stat_msi_fail(stat_fail)
  );

  // at most one vector bit set in any cycle
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if ($countones(msi_int) > 1) $display("FAIL onehot: msi_int=%h, required at most one bit", msi_int);
      else passed++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_irq(input int idx);
    irq_if.irq_valid = 1'b1;
    irq_if.irq_index = 11'(idx);
    cyc();
    irq_if.irq_valid = 1'b0;
  endtask

  task automatic wait_msi(output int n);
    logic [4:0] e;
    n = 0;
    while (msi_int === 32'h0 && n < 200) begin
      cyc();
      n++;
    end
    checks++;
    if (n >= 200) $display("FAIL msi_wait: msi_int=%h after %0d cycles, required a pulse", msi_int, n);
    else if (exp_q.size() == 0) $display("FAIL msi_unexpected: msi_int=%h, required none", msi_int);
    else begin
      e = exp_q.pop_front();
      if (msi_int !== (32'h1 << e)) $display("FAIL msi_vec: msi_int=%h, required %h", msi_int, 32'h1 << e);
      else passed++;
    end
  endtask

  task automatic finish_msi(input bit s, input bit f);
    cyc();
    irq_if.irq_valid = 1'b0;
    checks++;
    if (msi_int !== 32'h0) $display("FAIL msi_width: msi_int=%h one cycle later, required 0", msi_int);
    else passed++;
    sent = s;
    fail = f;
    cyc();
    sent = 1'b0;
    fail = 1'b0;
    checks++;
    if ({stat_sent, stat_fail} !== {s, f & ~s})
      $display("FAIL stat: sent/fail=%b%b, required %b%b", stat_sent, stat_fail, s, f & ~s);
    else passed++;
  endtask

  task automatic quiet(input int n);
    bit bad = 1'b0;
    repeat (n) begin
      cyc();
      if (msi_int !== 32'h0) bad = 1'b1;
    end
    checks++;
    if (bad) $display("FAIL quiet: msi_int pulsed within %0d cycles, required none", n);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; msi_enable = 4'h0; mmenable = 12'h0; sent = 1'b0; fail = 1'b0;
    irq_if.irq_valid = 1'b0; irq_if.irq_index = 11'd0;
    repeat (3) cyc();
    checks++;
    if ({msi_int, irq_if.irq_ready, stat_sent, stat_fail} !== 35'h0)
      $display("FAIL reset_outs: int=%h rdy=%b st=%b%b, required all 0", msi_int, irq_if.irq_ready, stat_sent, stat_fail);
    else passed++;
    checks++;
    if (|{sel, pend_status, pend_de, pend_fn, attr, tph_present, tph_type, st_tag, fn_num} !== 1'b0)
      $display("FAIL const_outs: some constant output nonzero, required 0");
    else passed++;
    rst_n = 1'b1;
    checks++;
    if (irq_if.irq_ready !== 1'b0) $display("FAIL ready_early: irq_ready=%b, required 0", irq_if.irq_ready);
    else passed++;
    cyc();
    checks++;
    if (irq_if.irq_ready !== 1'b1) $display("FAIL ready_rise: irq_ready=%b, required 1", irq_if.irq_ready);
    else passed++;
  endtask

  task automatic test_single();
    int n;
    mmenable = 12'd5; msi_enable = 4'h1;
    exp_q.push_back(5'd3);
    send_irq(3);
    checks++;
    if (msi_int !== 32'h0) $display("FAIL latency_early: msi_int=%h one cycle after request, required 0", msi_int);
    else passed++;
    wait_msi(n);
    checks++;
    if (n !== 1) $display("FAIL latency: %0d extra cycles, required 1", n);
    else passed++;
    finish_msi(1'b1, 1'b0);
    checks++;
    if (dut.pending_q !== 32'h0) $display("FAIL single_clear: pending=%h, required 0", dut.pending_q);
    else passed++;
    cyc();
    checks++;
    if (stat_sent !== 1'b0) $display("FAIL sent_pulse: stat_msi_sent=%b, required 0", stat_sent);
    else passed++;
  endtask

  task automatic test_coalesce();
    int n;
    mmenable = 12'd2;
    exp_q.push_back(5'd1);
    irq_if.irq_valid = 1'b1; irq_if.irq_index = 11'd1; cyc();
    irq_if.irq_index = 11'd5; cyc();
    irq_if.irq_index = 11'd9;
    wait_msi(n);
    finish_msi(1'b1, 1'b0);
    quiet(20);
    checks++;
    if (dut.pending_q !== 32'h0) $display("FAIL coalesce: pending=%h, required 0", dut.pending_q);
    else passed++;
    // vector 3 moves the pointer back to 0 for the round-robin check
    exp_q.push_back(5'd3);
    send_irq(3); wait_msi(n); finish_msi(1'b1, 1'b0);
    msi_enable = 4'h0;
    send_irq(2); send_irq(1); cyc();
    msi_enable = 4'h1;
    exp_q.push_back(5'd1); exp_q.push_back(5'd2);
    wait_msi(n); finish_msi(1'b1, 1'b0);
    wait_msi(n); finish_msi(1'b1, 1'b0);
  endtask

  task automatic test_fail_retry();
    int n;
    mmenable = 12'd3;
    msi_enable = 4'h0;
    send_irq(4); send_irq(6);
    msi_enable = 4'h1;
    exp_q.push_back(5'd4);
    wait_msi(n); finish_msi(1'b0, 1'b1);
    exp_q.push_back(5'd6); exp_q.push_back(5'd4);
    wait_msi(n);
    checks++;
    if (n !== RD + 1) $display("FAIL backoff: next msi after %0d cycles, required %0d", n, RD + 1);
    else passed++;
    finish_msi(1'b1, 1'b0);
    wait_msi(n); finish_msi(1'b1, 1'b0);
  endtask

  task automatic test_timeout();
    int n;
    bit bad = 1'b0;
    exp_q.push_back(5'd5); exp_q.push_back(5'd5);
    send_irq(5); wait_msi(n);
    cyc();
    repeat (TO - 1) begin
      cyc();
      if (msi_int !== 32'h0 || stat_fail !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) $display("FAIL timeout_early: activity before %0d wait cycles, required none", TO);
    else passed++;
    cyc();
    checks++;
    if (stat_fail !== 1'b1) $display("FAIL timeout: stat_msi_fail=%b, required 1", stat_fail);
    else passed++;
    wait_msi(n);
    checks++;
    if (n !== RD + 1) $display("FAIL timeout_retry: retry after %0d cycles, required %0d", n, RD + 1);
    else passed++;
    finish_msi(1'b1, 1'b1);
    checks++;
    if (dut.pending_q !== 32'h0) $display("FAIL sent_wins: pending=%h, required 0", dut.pending_q);
    else passed++;
  endtask

  task automatic test_enable_drain();
    int n;
    exp_q.push_back(5'd7);
    send_irq(7); wait_msi(n); finish_msi(1'b1, 1'b0);
    msi_enable = 4'h0;
    for (int i = 0; i < 8; i++) send_irq(i);
    quiet(10);
    checks++;
    if (dut.pending_q !== 32'h0000_00FF) $display("FAIL held: pending=%h, required 000000ff", dut.pending_q);
    else passed++;
    msi_enable = 4'h1;
    for (int i = 0; i < 8; i++) exp_q.push_back(5'(i));
    for (int i = 0; i < 8; i++) begin
      wait_msi(n);
      finish_msi(1'b1, 1'b0);
    end
    msi_enable = 4'h0;
    send_irq(7);
    mmenable = 12'd1;
    cyc();
    checks++;
    if (dut.pending_q !== 32'h0000_0002) $display("FAIL fold: pending=%h, required 00000002", dut.pending_q);
    else passed++;
    msi_enable = 4'h1;
    exp_q.push_back(5'd1);
    wait_msi(n); finish_msi(1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_wait();
    int n;
    mmenable = 12'd5;
    exp_q.push_back(5'd10);
    send_irq(10); wait_msi(n);
    send_irq(12);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({msi_int, irq_if.irq_ready, stat_sent, stat_fail} !== 35'h0 || dut.pending_q !== 32'h0)
      $display("FAIL rst_wait: int=%h rdy=%b pend=%h, required all 0", msi_int, irq_if.irq_ready, dut.pending_q);
    else passed++;
    cyc(); cyc();
    rst_n = 1'b1;
    sent = 1'b1;
    cyc();
    sent = 1'b0;
    checks++;
    if (stat_sent !== 1'b0) $display("FAIL late_sent: stat_msi_sent=%b, required 0", stat_sent);
    else passed++;
    quiet(10);
  endtask

  initial begin
    test_reset();
    test_single();
    test_coalesce();
    test_fail_retry();
    test_timeout();
    test_enable_drain();
    test_reset_mid_wait();
    checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard: %0d expected MSIs never seen, required 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
